alu_ab_datapath: RTL and testbench

// - 4-bit accumulator datapath for the SAP-style CPU: accumulator A, B register and ALU in one block.
// - Inputs: control-sequencer strobes, IR opcode, RAM and TMP buses. Outputs: operand buses to TMP/RAM/OUT, Z and carry.
// - Covers MOV A,[m], XCHG A,B (through TMP), ADD, SUB, RCL B, PUSH/POP B.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/alu_core.sv | 53 +++++
 rtl/alu_ab_datapath.sv | 102 ++++++++++
 tb/tb_alu_ab_datapath.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the SAP-style CPU: datapath width and the IR opcodes
// that select the ALU function.
package cpu_pkg;
    localparam int W = 4;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_JZ   = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_RCL  = 4'b1001;
    localparam logic [3:0] OP_ADDT = 4'b1100;
    localparam logic [3:0] OP_SUBT = 4'b1101;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, carry/borrow and zero from opcode and operands.
// Opcodes outside the ALU set pass A through with no carry.
module alu_core
    import cpu_pkg::*;
(
    input  logic [3:0]   opcode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] tmp,
    output logic [W-1:0] res,
    output logic         c,
    output logic         zero
);
    logic [W:0] wide;

    // One extra bit on add/sub captures carry-out, or the borrow when A < operand.
    always_comb begin
        wide = '0;
        res  = a;
        c    = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                res  = wide[W-1:0];
                c    = wide[W];
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                res  = wide[W-1:0];
                c    = wide[W];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_ADDT: begin
                wide = {1'b0, a} + {1'b0, tmp};
                res  = wide[W-1:0];
                c    = wide[W];
            end
            OP_SUBT: begin
                wide = {1'b0, a} - {1'b0, tmp};
                res  = wide[W-1:0];
                c    = wide[W];
            end
            default: begin
                res = a;
                c   = 1'b0;
            end
        endcase
    end

    assign zero = (res == '0);
endmodule

// File: rtl/alu_ab_datapath.sv
// Accumulator A, B register and ALU for the SAP-style CPU; registers Z/carry
// on execute and drives AND-gated operand buses.
module alu_ab_datapath
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   opcode,
    input  logic [W-1:0] ram_to_a,
    input  logic [W-1:0] tmp_to_b,
    input  logic [W-1:0] tmp_to_alu,
    input  logic [W-1:0] ram_to_b,
    input  logic         carry_in,
    input  logic         la_ram,
    input  logic         la_b,
    input  logic         la_alu,
    input  logic         ea_carry,
    input  logic         ea_tmp,
    input  logic         ea_ram,
    input  logic         ea_out,
    input  logic         lb_tmp,
    input  logic         lb_alu,
    input  logic         lb_pop,
    input  logic         lcarry,
    input  logic         ercl,
    input  logic         eb_a,
    input  logic         eb_push,
    input  logic         eu,
    output logic [W-1:0] a_to_tmp,
    output logic [W-1:0] a_to_ram,
    output logic [W-1:0] a_to_out,
    output logic [W-1:0] b_to_ram,
    output logic         z_flag,
    output logic         carry_alu,
    output logic         carry_from_a,
    output logic         carry_from_b
);
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] b_to_a;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         alu_zero;

    alu_core u_alu (
        .opcode (opcode),
        .a      (a_reg),
        .b      (b_reg),
        .tmp    (tmp_to_alu),
        .res    (alu_res),
        .c      (alu_c),
        .zero   (alu_zero)
    );

    // eb_a gates the B->A bus, so la_b without it loads zero.
    assign b_to_a   = eb_a    ? b_reg : '0;
    assign a_to_tmp = ea_tmp  ? a_reg : '0;
    assign a_to_ram = ea_ram  ? a_reg : '0;
    assign a_to_out = ea_out  ? a_reg : '0;
    assign b_to_ram = eb_push ? b_reg : '0;

    // Both registers sample old values on the same edge, giving swap semantics.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            z_flag       <= 1'b0;
            carry_alu    <= 1'b0;
            carry_from_a <= 1'b0;
            carry_from_b <= 1'b0;
        end else begin
            if (eu) begin
                z_flag    <= alu_zero;
                carry_alu <= alu_c;
            end

            if (la_ram) begin
                a_reg <= ram_to_a;
            end else if (la_b) begin
                a_reg <= b_to_a;
            end else if (la_alu) begin
                a_reg <= alu_res;
            end else if (ea_carry) begin
                a_reg        <= {a_reg[W-2:0], carry_in};
                carry_from_a <= a_reg[W-1];
            end

            if (lb_pop) begin
                b_reg <= ram_to_b;
            end else if (lb_tmp) begin
                b_reg <= tmp_to_b;
            end else if (lb_alu) begin
                b_reg <= alu_res;
            end else if (ercl) begin
                b_reg        <= {b_reg[W-2:0], carry_in};
                carry_from_b <= b_reg[W-1];
            end else if (lcarry) begin
                b_reg <= {{(W-1){1'b0}}, carry_in};
            end
        end
    end
endmodule

// File: tb/tb_alu_ab_datapath.sv
// Self-checking bench for alu_ab_datapath: directed SAP instruction sequences
// followed by random strobes, compared against an arithmetic reference model.
module tb_alu_ab_datapath;
    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic [3:0] ram_to_a, tmp_to_b, tmp_to_alu, ram_to_b;
    logic       carry_in;
    logic       la_ram, la_b, la_alu, ea_carry;
    logic       ea_tmp, ea_ram, ea_out;
    logic       lb_tmp, lb_alu, lb_pop, lcarry, ercl;
    logic       eb_a, eb_push, eu;
    logic [3:0] a_to_tmp, a_to_ram, a_to_out, b_to_ram;
    logic       z_flag, carry_alu, carry_from_a, carry_from_b;

    int errors = 0;
    int checks = 0;
    int ma = 0, mb = 0, mz = 0, mc = 0, mcfa = 0, mcfb = 0;

    alu_ab_datapath dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .ram_to_a(ram_to_a), .tmp_to_b(tmp_to_b), .tmp_to_alu(tmp_to_alu),
        .ram_to_b(ram_to_b), .carry_in(carry_in),
        .la_ram(la_ram), .la_b(la_b), .la_alu(la_alu), .ea_carry(ea_carry),
        .ea_tmp(ea_tmp), .ea_ram(ea_ram), .ea_out(ea_out),
        .lb_tmp(lb_tmp), .lb_alu(lb_alu), .lb_pop(lb_pop), .lcarry(lcarry),
        .ercl(ercl), .eb_a(eb_a), .eb_push(eb_push), .eu(eu),
        .a_to_tmp(a_to_tmp), .a_to_ram(a_to_ram), .a_to_out(a_to_out),
        .b_to_ram(b_to_ram), .z_flag(z_flag), .carry_alu(carry_alu),
        .carry_from_a(carry_from_a), .carry_from_b(carry_from_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearStrobes();
        reset = 1'b1; opcode = 4'b0000; carry_in = 1'b0;
        ram_to_a = 4'h0; tmp_to_b = 4'h0; tmp_to_alu = 4'h0; ram_to_b = 4'h0;
        la_ram = 0; la_b = 0; la_alu = 0; ea_carry = 0;
        ea_tmp = 0; ea_ram = 0; ea_out = 0;
        lb_tmp = 0; lb_alu = 0; lb_pop = 0; lcarry = 0; ercl = 0;
        eb_a = 0; eb_push = 0; eu = 0;
    endtask

    // Reference ALU from the opcode table using plain integer arithmetic.
    task automatic aluModel(input int op, input int a, input int b, input int t,
                            output int r, output int c);
        r = a; c = 0;
        case (op)
            1:  begin r = (a + b) % 16;      c = (a + b > 15) ? 1 : 0; end
            2:  begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            5:  r = a & b;
            6:  r = a | b;
            8:  r = a ^ b;
            12: begin r = (a + t) % 16;      c = (a + t > 15) ? 1 : 0; end
            13: begin r = (a - t + 16) % 16; c = (a < t) ? 1 : 0; end
            default: begin r = a; c = 0; end
        endcase
    endtask

    task automatic modelStep();
        int r, c, na, nb;
        aluModel(int'(opcode), ma, mb, int'(tmp_to_alu), r, c);
        if (!reset) begin
            ma = 0; mb = 0; mz = 0; mc = 0; mcfa = 0; mcfb = 0;
            return;
        end
        na = ma; nb = mb;
        if (eu) begin mz = (r == 0) ? 1 : 0; mc = c; end
        if (la_ram)        na = int'(ram_to_a);
        else if (la_b)     na = eb_a ? mb : 0;
        else if (la_alu)   na = r;
        else if (ea_carry) begin na = (ma * 2 + int'(carry_in)) % 16; mcfa = ma / 8; end
        if (lb_pop)        nb = int'(ram_to_b);
        else if (lb_tmp)   nb = int'(tmp_to_b);
        else if (lb_alu)   nb = r;
        else if (ercl)     begin nb = (mb * 2 + int'(carry_in)) % 16; mcfb = mb / 8; end
        else if (lcarry)   nb = int'(carry_in);
        ma = na; mb = nb;
    endtask

    // Checks the enabled buses before the edge, clocks, then reads state back through the buses.
    task automatic applyStimulus(input string tag);
        #1;
        checkOutput({tag, "_a_to_tmp"}, {4'h0, a_to_tmp}, 8'(ea_tmp  ? ma : 0));
        checkOutput({tag, "_a_to_ram"}, {4'h0, a_to_ram}, 8'(ea_ram  ? ma : 0));
        checkOutput({tag, "_b_to_ram"}, {4'h0, b_to_ram}, 8'(eb_push ? mb : 0));
        modelStep();
        @(posedge clk);
        #1;
        clearStrobes();
        ea_out = 1; eb_push = 1;
        #1;
        checkOutput({tag, "_A"},    {4'h0, a_to_out}, 8'(ma));
        checkOutput({tag, "_B"},    {4'h0, b_to_ram}, 8'(mb));
        checkOutput({tag, "_Z"},    {7'h0, z_flag},       8'(mz));
        checkOutput({tag, "_C"},    {7'h0, carry_alu},    8'(mc));
        checkOutput({tag, "_cfa"},  {7'h0, carry_from_a}, 8'(mcfa));
        checkOutput({tag, "_cfb"},  {7'h0, carry_from_b}, 8'(mcfb));
        ea_out = 0; eb_push = 0;
    endtask

    initial begin
        clearStrobes();
        @(posedge clk); #1;

        // Reset wins over every strobe.
        reset = 0; la_ram = 1; ram_to_a = 4'b1011; lb_pop = 1; ram_to_b = 4'b0110;
        eu = 1; opcode = 4'b0001; ercl = 1; ea_carry = 1;
        applyStimulus("reset");
        checkOutput("reset_A_const", {4'h0, a_to_out}, 8'h00);

        // MOV A,[9]; XCHG via TMP; MOV A,[A]; SUB -> zero.
        la_ram = 1; ram_to_a = 4'b1011;                 applyStimulus("mov_a");
        ea_tmp = 1; lb_tmp = 1; tmp_to_b = 4'b1011; la_b = 1; eb_a = 1;
        applyStimulus("xchg");
        la_ram = 1; ram_to_a = 4'b1011;                 applyStimulus("mov_a2");
        opcode = 4'b0010; eu = 1; la_alu = 1;           applyStimulus("sub_zero");
        checkOutput("sub_zero_Z_const", {7'h0, z_flag}, 8'h01);

        // 1011 + 1011 -> 0110 carry.
        la_ram = 1; ram_to_a = 4'b1011;                 applyStimulus("load_a");
        opcode = 4'b0001; eu = 1; la_alu = 1;           applyStimulus("add_carry");
        checkOutput("add_carry_A_const", {4'h0, a_to_out}, 8'h06);

        // RCL B with carry_in=1.
        lb_pop = 1; ram_to_b = 4'b1011;                 applyStimulus("pop_b");
        ercl = 1; carry_in = 1;                         applyStimulus("rcl_b");
        checkOutput("rcl_b_B_const", {4'h0, b_to_ram}, 8'h07);

        // Borrow wrap 0000-0001 and carry wrap 1111+0001.
        la_ram = 1; ram_to_a = 4'b0000; lb_pop = 1; ram_to_b = 4'b0001;
        applyStimulus("load_ab");
        opcode = 4'b0010; eu = 1; la_alu = 1;           applyStimulus("sub_wrap");
        checkOutput("sub_wrap_A_const", {4'h0, a_to_out}, 8'h0f);
        opcode = 4'b0001; eu = 1; la_alu = 1;           applyStimulus("add_wrap");
        checkOutput("add_wrap_C_const", {7'h0, carry_alu}, 8'h01);

        // Priority, A rotate, TMP operand ops, lcarry.
        la_ram = 1; la_alu = 1; opcode = 4'b0001; ram_to_a = 4'b1001;
        applyStimulus("prio_a");
        ea_carry = 1; carry_in = 0;                     applyStimulus("rot_a");
        opcode = 4'b1100; tmp_to_alu = 4'b0111; eu = 1; lb_alu = 1;
        applyStimulus("addt_b");
        opcode = 4'b1101; tmp_to_alu = 4'b1111; eu = 1; la_alu = 1;
        applyStimulus("subt_a");
        lcarry = 1; carry_in = 1;                       applyStimulus("lcarry");
        ea_out = 0; #1;
        checkOutput("ea_out_off", {4'h0, a_to_out}, 8'h00);
        eb_push = 1; #1;
        checkOutput("eb_push_on", {4'h0, b_to_ram}, 8'(mb));
        eb_push = 0;

        for (int i = 0; i < 300; i++) begin
            reset      = ($urandom_range(0, 24) != 0);
            opcode     = 4'($urandom_range(0, 15));
            ram_to_a   = 4'($urandom_range(0, 15));
            tmp_to_b   = 4'($urandom_range(0, 15));
            tmp_to_alu = 4'($urandom_range(0, 15));
            ram_to_b   = 4'($urandom_range(0, 15));
            carry_in   = 1'($urandom_range(0, 1));
            la_ram  = ($urandom_range(0, 4) == 0); la_b   = ($urandom_range(0, 4) == 0);
            la_alu  = ($urandom_range(0, 2) == 0); ea_carry = ($urandom_range(0, 3) == 0);
            ea_tmp  = 1'($urandom_range(0, 1));    ea_ram = 1'($urandom_range(0, 1));
            lb_tmp  = ($urandom_range(0, 4) == 0); lb_alu = ($urandom_range(0, 3) == 0);
            lb_pop  = ($urandom_range(0, 4) == 0); lcarry = ($urandom_range(0, 3) == 0);
            ercl    = ($urandom_range(0, 3) == 0); eb_a   = ($urandom_range(0, 3) != 0);
            eb_push = 1'($urandom_range(0, 1));    eu     = 1'($urandom_range(0, 1));
            applyStimulus("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
